// File: rtl/nco_seq_ctrl.sv
// Note sequencer: steps through a programmable {fcw, duration} table and
// drives the NCO frequency control word, counting durations in NCO
// sample fetches (next_sample strobes).
module nco_seq_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned FCW_W = 24,
  parameter int unsigned DUR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [FCW_W-1:0] wr_fcw,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic [IDX_W-1:0] last_idx,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  input  logic             next_sample,
  output logic [FCW_W-1:0] fcw,
  output logic [IDX_W-1:0] note_idx,
  output logic             busy,
  output logic             done
);

  typedef struct packed {
    logic [FCW_W-1:0] fcw;
    logic [DUR_W-1:0] dur;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  entry_t           table_q [DEPTH];
  state_t           state;
  logic [DUR_W-1:0] remaining;
  logic [IDX_W-1:0] last_cap;

  logic [IDX_W-1:0] idx_inc;
  entry_t           ent_next;
  entry_t           ent_zero;

  // A zero duration still plays for one sample
  function automatic logic [DUR_W-1:0] sat_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  // Next-entry lookup; reads see pre-edge table contents
  always_comb begin
    idx_inc  = note_idx + IDX_W'(1);
    ent_next = table_q[idx_inc];
    ent_zero = table_q[0];
  end

  // Note table storage, writable in any state, not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      table_q[wr_addr] <= {wr_fcw, wr_dur};
    end
  end

  // Sequencer FSM with registered outputs; stop overrides everything but rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      fcw       <= '0;
      note_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      last_cap  <= '0;
    end else if (stop) begin
      state     <= ST_IDLE;
      fcw       <= '0;
      note_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          fcw  <= '0;
          if (start) begin
            state     <= ST_PLAY;
            busy      <= 1'b1;
            note_idx  <= '0;
            fcw       <= ent_zero.fcw;
            remaining <= sat_dur(ent_zero.dur);
            last_cap  <= last_idx;
          end
        end
        ST_PLAY: begin
          done <= 1'b0;
          busy <= 1'b1;
          if (next_sample) begin
            if (remaining > DUR_W'(1)) begin
              remaining <= remaining - DUR_W'(1);
            end else if (note_idx != last_cap) begin
              note_idx  <= idx_inc;
              fcw       <= ent_next.fcw;
              remaining <= sat_dur(ent_next.dur);
            end else if (loop_en) begin
              note_idx  <= '0;
              fcw       <= ent_zero.fcw;
              remaining <= sat_dur(ent_zero.dur);
            end else begin
              state     <= ST_DONE;
              fcw       <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              remaining <= '0;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          fcw   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          fcw   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_seq_ctrl.sv
// Directed bench for the note sequencer.
module tb_nco_seq_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned FCW_W = 24;
  localparam int unsigned DUR_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [IDX_W-1:0] wr_addr = '0;
  logic [FCW_W-1:0] wr_fcw = '0;
  logic [DUR_W-1:0] wr_dur = '0;
  logic [IDX_W-1:0] last_idx = '0;
  logic             loop_en = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             next_sample = 1'b0;
  logic [FCW_W-1:0] fcw;
  logic [IDX_W-1:0] note_idx;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  nco_seq_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .FCW_W(FCW_W), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_fcw(wr_fcw),
    .wr_dur(wr_dur), .last_idx(last_idx), .loop_en(loop_en), .start(start),
    .stop(stop), .next_sample(next_sample), .fcw(fcw), .note_idx(note_idx),
    .busy(busy), .done(done)
  );

  always #4 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [IDX_W-1:0] a, input logic [FCW_W-1:0] f, input logic [DUR_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_fcw = f; wr_dur = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_ns();
    next_sample = 1'b1;
    tick();
    next_sample = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    int n;
    int gap;
    logic [FCW_W-1:0] exp_f;
    logic saw_done;

    // Reset state
    #1;
    check("rst_fcw", 32'(fcw), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_idx", 32'(note_idx), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // 1: one-shot two-note play
    wr(4'd0, 24'h010000, 16'd3);
    wr(4'd1, 24'h00EC3C, 16'd2);
    last_idx = 4'd1; loop_en = 1'b0;
    pulse_start();
    check("t1_fcw0", 32'(fcw), 32'h010000);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_idx0", 32'(note_idx), 32'h0);
    pulse_ns(); pulse_ns();
    check("t1_fcw_hold", 32'(fcw), 32'h010000);
    pulse_ns();
    check("t1_fcw1", 32'(fcw), 32'h00EC3C);
    check("t1_idx1", 32'(note_idx), 32'h1);
    pulse_ns();
    check("t1_fcw1_hold", 32'(fcw), 32'h00EC3C);
    check("t1_done_early", 32'(done), 32'h0);
    pulse_ns();
    check("t1_done", 32'(done), 32'h1);
    check("t1_fcw_end", 32'(fcw), 32'h0);
    tick();
    check("t1_done_1cyc", 32'(done), 32'h0);
    check("t1_busy_end", 32'(busy), 32'h0);

    // 2: looped play, 12 samples at random spacing
    loop_en = 1'b1;
    pulse_start();
    saw_done = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      gap = int'($urandom_range(9, 2));
      pulse_ns();
      if (done) saw_done = 1'b1;
      n = k % 5;
      exp_f = (n < 3) ? 24'h010000 : 24'h00EC3C;
      check($sformatf("t2_fcw_s%0d", k), 32'(fcw), 32'(exp_f));
      for (int g = 1; g < gap; g++) begin
        tick();
        if (done) saw_done = 1'b1;
      end
    end
    check("t2_no_done", 32'(saw_done), 32'h0);
    check("t2_busy", 32'(busy), 32'h1);

    // 3: stop coincident with a terminal sample (entry0 has one sample left)
    stop = 1'b1; next_sample = 1'b1;
    tick();
    stop = 1'b0; next_sample = 1'b0;
    check("t3_fcw", 32'(fcw), 32'h0);
    check("t3_idx", 32'(note_idx), 32'h0);
    check("t3_busy", 32'(busy), 32'h0);
    check("t3_done", 32'(done), 32'h0);
    tick();
    check("t3_done_after", 32'(done), 32'h0);
    pulse_start();
    check("t3_restart_fcw", 32'(fcw), 32'h010000);
    check("t3_restart_idx", 32'(note_idx), 32'h0);
    check("t3_restart_busy", 32'(busy), 32'h1);

    // 5: rewrite entry0 while entry1 plays
    pulse_ns(); pulse_ns(); pulse_ns();
    check("t5_idx1", 32'(note_idx), 32'h1);
    wr(4'd0, 24'h020000, 16'd3);
    check("t5_e1_fcw", 32'(fcw), 32'h00EC3C);
    pulse_ns();
    check("t5_e1_hold", 32'(fcw), 32'h00EC3C);
    pulse_ns();
    check("t5_wrap_fcw", 32'(fcw), 32'h020000);
    check("t5_wrap_idx", 32'(note_idx), 32'h0);
    pulse_stop();
    check("t5_stop_busy", 32'(busy), 32'h0);

    // 4: zero duration, single note
    wr(4'd0, 24'h123456, 16'd0);
    last_idx = 4'd0; loop_en = 1'b0;
    pulse_ns();
    check("t4_idle_ns_fcw", 32'(fcw), 32'h0);
    check("t4_idle_ns_busy", 32'(busy), 32'h0);
    pulse_start();
    check("t4_fcw", 32'(fcw), 32'h123456);
    pulse_ns();
    check("t4_done", 32'(done), 32'h1);
    check("t4_fcw_end", 32'(fcw), 32'h0);
    tick();
    check("t4_done_1cyc", 32'(done), 32'h0);

    // 6: asynchronous reset mid-play
    wr(4'd0, 24'h010000, 16'd3);
    last_idx = 4'd1;
    pulse_start();
    pulse_ns(); pulse_ns(); pulse_ns();
    check("t6_pre_idx", 32'(note_idx), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_fcw", 32'(fcw), 32'h0);
    check("t6_async_busy", 32'(busy), 32'h0);
    check("t6_async_idx", 32'(note_idx), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    check("t6_restart_fcw", 32'(fcw), 32'h010000);
    check("t6_restart_busy", 32'(busy), 32'h1);
    pulse_ns(); pulse_ns(); pulse_ns();
    check("t6_next_fcw", 32'(fcw), 32'h00EC3C);
    check("t6_next_idx", 32'(note_idx), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
